a_buffer_loader: RTL
====================

Name: a_buffer_loader

Overview:
- Upstream fill engine for the activation (A) buffer.
- On `start`, streams a tile of `num_rows` × `row_len` activations from the global activation BRAM and writes them into the A-buffer row RAMs using the buffer's write port (`bram_to_ram_w_addr` / `w_en` / `w_data`).
- Row r of the tile goes to row RAM r, at consecutive addresses from `dst_base_addr`.
- Runs before the systolic controller enables the buffer's read side; signals completion with a one-cycle `done` pulse.

Parameters:
- RAM_SIZE, 1024, depth of each A-buffer row RAM
- ADDR_WIDTH, $clog2(RAM_SIZE), row RAM address width
- ARRAY_N, 8, number of row RAMs (array rows)
- ACT_WIDTH, 8, activation width
- SRC_ADDR_WIDTH, 16, global BRAM address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start request, sampled only in IDLE
- src_base_addr  in  SRC_ADDR_WIDTH  BRAM address of element (0,0)
- dst_base_addr  in  ADDR_WIDTH  row RAM address for column 0
- num_rows  in  $clog2(ARRAY_N)+1  tile rows (0..ARRAY_N)
- row_len  in  ADDR_WIDTH+1  elements per row (0..RAM_SIZE)
- bram_rd_en  out  1  BRAM read strobe
- bram_rd_addr  out  SRC_ADDR_WIDTH  BRAM read address
- bram_rd_data  in  ACT_WIDTH  BRAM data, valid exactly 1 cycle after `bram_rd_en`
- bram_to_ram_w_addr  out  ADDR_WIDTH  row RAM write address
- bram_to_ram_w_en  out  ARRAY_N  one-hot row write enable
- bram_to_ram_w_data  out  ACT_WIDTH  write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - state = IDLE.
  - `bram_rd_en`, `bram_rd_addr`, `bram_to_ram_w_en`, `bram_to_ram_w_addr`, `busy` and `done` are all 0.
  - Reset mid-transfer aborts immediately: no further reads or writes, and no `done` pulse.
- Start:
  - In IDLE, `start` high latches `src_base_addr`, `dst_base_addr`, `num_rows` and `row_len`.
  - `num_rows` > ARRAY_N is clamped to ARRAY_N.
  - `start` outside IDLE is ignored. Input changes after the latch have no effect.
- Data layout:
  - Element (r,k) is read from BRAM at `src_base + r*row_len + k`, truncated to SRC_ADDR_WIDTH (wraps).
  - It is written to row RAM r at `dst_base + k`, modulo RAM_SIZE (ADDR_WIDTH truncation, wraps).
  - Order is r outer, k inner, one element per cycle with no bubbles.
  - The source pointer is a running counter incremented per read; no multiplier.
- States:
  - IDLE:
    - `start` with `num_rows`==0 or `row_len`==0 → DONE.
    - `start` otherwise → READ.
  - READ:
    - `bram_rd_en`=1 with current address every cycle; `busy`=1.
    - The last element (r=N-1, k=L-1) is issued → DRAIN.
  - DRAIN: no read; `busy`=1; the final write occurs this cycle → DONE.
  - DONE: `done`=1, `busy`=0, exactly one cycle → IDLE.
- Write pipeline:
  - A read issued in cycle t is written in cycle t+1.
  - `bram_to_ram_w_en` (one-hot bit r) and `bram_to_ram_w_addr` are registered copies of the row/column issued in t.
  - `bram_to_ram_w_data` = `bram_rd_data` (combinational pass-through).
  - `bram_to_ram_w_en`=0 whenever no write is pending. At most one bit is ever set.
- Timing (start sampled at edge 0, N×L tile, N,L>0):
  - Reads in cycles 1..N·L; writes in cycles 2..N·L+1.
  - `busy` high cycles 1..N·L+1.
  - `done` in cycle N·L+2.
  - A new `start` is accepted from cycle N·L+3.
- Zero-size tile: `done` in cycle 1, `busy` never asserted, no reads or writes.
- Row boundary: k wraps to 0 and r increments in the same cycle, with no gap in `bram_rd_en`.
- Concurrency: the A buffer's Intranet_on path must not be active while `busy`. This is the controller's responsibility and is not checked here.

Test Plan:
- N=2, L=3, src=0x0100, dst=5, BRAM[a]=a[7:0]:
  - Reads 0x100..0x105 in cycles 1..6.
  - Writes: w_en=0x01 at addr 5,6,7 with data 00,01,02; then w_en=0x02 at addr 5,6,7 with data 03,04,05.
  - `done` in cycle 8.
- N=ARRAY_N=8, L=1, dst=0:
  - 8 consecutive writes at addr 0 with w_en 0x01,0x02,…,0x80.
  - `busy` high for 9 cycles.
- Zero size: `num_rows`=0 (and separately `row_len`=0) → `done` in cycle 1, `bram_rd_en` and `w_en` never high.
- Wrap: dst=1022, L=4, N=1 → write addresses 1022,1023,0,1. Separately, src=0xFFFE → read addresses FFFE,FFFF,0000,…
- `start` re-asserted during busy and `num_rows`=15 (clamp):
  - The second start is ignored.
  - `num_rows`=15 transfers 8 rows only.
- Reset asserted in cycle 3 of an N=4, L=4 transfer → from the next cycle all outputs are 0, no `done`. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/a_buffer_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : a_buffer_loader_if
// Description : Start/config, global-BRAM read and A-buffer write-port
//               signals of the activation buffer fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface a_buffer_loader_if #(
    parameter int RAM_SIZE       = 1024,
    parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
    parameter int ARRAY_N        = 8,
    parameter int ACT_WIDTH      = 8,
    parameter int SRC_ADDR_WIDTH = 16
);
    logic                          start;
    logic [SRC_ADDR_WIDTH-1:0]     src_base_addr;
    logic [ADDR_WIDTH-1:0]         dst_base_addr;
    logic [$clog2(ARRAY_N):0]      num_rows;
    logic [ADDR_WIDTH:0]           row_len;
    logic                          bram_rd_en;
    logic [SRC_ADDR_WIDTH-1:0]     bram_rd_addr;
    logic [ACT_WIDTH-1:0]          bram_rd_data;
    logic [ADDR_WIDTH-1:0]         bram_to_ram_w_addr;
    logic [ARRAY_N-1:0]            bram_to_ram_w_en;
    logic [ACT_WIDTH-1:0]          bram_to_ram_w_data;
    logic                          busy;
    logic                          done;

    // Controller plus global BRAM side
    modport master (
        output start, src_base_addr, dst_base_addr, num_rows, row_len, bram_rd_data,
        input  bram_rd_en, bram_rd_addr, bram_to_ram_w_addr, bram_to_ram_w_en,
               bram_to_ram_w_data, busy, done
    );

    // Loader side
    modport slave (
        input  start, src_base_addr, dst_base_addr, num_rows, row_len, bram_rd_data,
        output bram_rd_en, bram_rd_addr, bram_to_ram_w_addr, bram_to_ram_w_en,
               bram_to_ram_w_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/a_buffer_loader.sv
`default_nettype none
// ============================================================================
// Module      : a_buffer_loader
// Description : Streams a num_rows x row_len activation tile from the global
//               BRAM into the A-buffer row RAMs, one element per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module a_buffer_loader #(
    parameter int RAM_SIZE       = 1024,
    parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
    parameter int ARRAY_N        = 8,
    parameter int ACT_WIDTH      = 8,
    parameter int SRC_ADDR_WIDTH = 16
) (
    input wire                  clk,
    input wire                  reset,
    a_buffer_loader_if.slave    bus
);
    localparam int c_row_w = $clog2(ARRAY_N) + 1;
    localparam int c_len_w = ADDR_WIDTH + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [ARRAY_N-1:0] c_row0_onehot = {{(ARRAY_N-1){1'b0}}, 1'b1};

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [SRC_ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0]     r_dst_base;
    logic [c_row_w-1:0]        r_num_rows;
    logic [c_len_w-1:0]        r_row_len;
    logic [c_row_w-1:0]        r_row;
    logic [c_len_w-1:0]        r_col;
    logic [ARRAY_N-1:0]        r_w_en;
    logic [ADDR_WIDTH-1:0]     r_w_addr;
    logic                      w_rd_en;
    logic                      w_busy;
    logic                      w_done;
    logic [c_row_w-1:0]        w_num_rows_clamped;
    logic                      w_zero_tile;
    logic                      w_row_end;
    logic                      w_last;

    assign w_num_rows_clamped = (bus.num_rows > c_row_w'(ARRAY_N)) ? c_row_w'(ARRAY_N)
                                                                   : bus.num_rows;
    assign w_zero_tile = (bus.num_rows == '0) || (bus.row_len == '0);
    assign w_row_end   = (r_col == r_row_len - c_len_w'(1));
    assign w_last      = w_row_end && (r_row == r_num_rows - c_row_w'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_next_state = w_zero_tile ? c_st_done : c_st_read;
                end
            end
            c_st_read: begin
                if (w_last) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: w_next_state = c_st_done;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_rd_en = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            c_st_read: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
            end
            c_st_drain: w_busy = 1'b1;
            c_st_done:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Config latch, running (r,k)/source counters and the one-stage write pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ptr  <= '0;
            r_dst_base <= '0;
            r_num_rows <= '0;
            r_row_len  <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_w_en     <= '0;
            r_w_addr   <= '0;
        end else begin
            r_w_en <= '0;
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_src_ptr  <= bus.src_base_addr;
                        r_dst_base <= bus.dst_base_addr;
                        r_num_rows <= w_num_rows_clamped;
                        r_row_len  <= bus.row_len;
                        r_row      <= '0;
                        r_col      <= '0;
                    end
                end
                c_st_read: begin
                    // Element issued now is written next cycle to row r_row
                    r_w_en    <= c_row0_onehot << r_row;
                    r_w_addr  <= r_dst_base + r_col[ADDR_WIDTH-1:0];
                    r_src_ptr <= r_src_ptr + SRC_ADDR_WIDTH'(1);
                    if (w_row_end) begin
                        r_col <= '0;
                        r_row <= r_row + c_row_w'(1);
                    end else begin
                        r_col <= r_col + c_len_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bram_rd_en         = w_rd_en;
    assign bus.bram_rd_addr       = w_rd_en ? r_src_ptr : '0;
    assign bus.busy               = w_busy;
    assign bus.done               = w_done;
    assign bus.bram_to_ram_w_en   = r_w_en;
    assign bus.bram_to_ram_w_addr = r_w_addr;
    assign bus.bram_to_ram_w_data = bus.bram_rd_data;
endmodule
`default_nettype wire
